cfg_register_loader: RTL and testbench

- Multicart configuration register file with staged writes, atomic commit, lockout and mapper-reset sequencing.
- The menu writes shadow registers through the CPU bus decoder, then issues a commit. Only a commit updates the active outputs, in one cycle.
- The active outputs (cpu_base, prg_mask, chr_mask, sram_page, enables, four_screen, mapper select) feed the top-level address and strobe datapath and the mapper logic.
- A lockout freezes the configuration until reset, so the running game cannot remap the cart.

---
 rtl/cfg_register_loader_if.sv | 23 ++
 rtl/cfg_register_loader.sv | 139 +++++++++++++
 tb/tb_cfg_register_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cfg_register_loader_if.sv
// Configuration bus between the CPU bus decoder and the register loader.
interface cfg_register_loader_if;
   logic       cfg_wr;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] cfg_rdata;

   // The bus decoder drives writes and addresses and receives readback.
   modport master (
      output cfg_wr,
      output cfg_addr,
      output cfg_data,
      input  cfg_rdata
   );

   // The register loader receives writes and drives readback.
   modport slave (
      input  cfg_wr,
      input  cfg_addr,
      input  cfg_data,
      output cfg_rdata
   );
endinterface

// File: rtl/cfg_register_loader.sv
// Multicart configuration registers: staged shadow writes, atomic commit,
// lockout until reset, and a fixed-length mapper reset pulse.
module cfg_register_loader #(
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned MAPPER_BITS  = 5
) (
   input  logic                   m2,
   input  logic                   reset,
   cfg_register_loader_if.slave   bus,
   output logic [12:0]            cpu_base,
   output logic [6:0]             prg_mask,
   output logic [4:0]             chr_mask,
   output logic [MAPPER_BITS-1:0] mapper,
   output logic                   sram_enabled,
   output logic                   map_rom_on_6000,
   output logic                   prg_write_enabled,
   output logic                   chr_write_enabled,
   output logic                   four_screen,
   output logic [1:0]             sram_page,
   output logic                   locked,
   output logic                   mapper_reset,
   output logic                   busy
);
   localparam int unsigned CNT_W     = $clog2(RESET_CYCLES + 1);
   localparam logic [6:0]  PRG_RST   = 7'b1111000;
   // R5 layout: [6] four_screen [5] chr_we [4] prg_we [3] rom_6000 [2:1] page [0] sram_en
   localparam logic [6:0]  FLAGS_RST = 7'b0100000;

   logic [7:0]             r_sh_base_hi;
   logic [4:0]             r_sh_base_lo;
   logic [6:0]             r_sh_prg;
   logic [4:0]             r_sh_chr;
   logic [MAPPER_BITS-1:0] r_sh_map;
   logic [6:0]             r_sh_flags;

   logic [12:0]            r_act_base;
   logic [6:0]             r_act_prg;
   logic [4:0]             r_act_chr;
   logic [MAPPER_BITS-1:0] r_act_map;
   logic [6:0]             r_act_flags;
   logic                   r_locked;
   logic [CNT_W-1:0]       r_cnt;
   logic [7:0]             r_rdata;

   logic                   w_wr_ok;
   logic                   w_commit;
   logic [7:0]             w_rdata;

   assign w_wr_ok  = bus.cfg_wr & ~r_locked;
   assign w_commit = w_wr_ok & (bus.cfg_addr == 3'd7) & bus.cfg_data[0];

   // Readback mux of the shadow register selected by cfg_addr; R6/R7 read 0.
   always_comb begin
      w_rdata = '0;
      case (bus.cfg_addr)
         3'd0:    w_rdata = r_sh_base_hi;
         3'd1:    w_rdata = {3'b000, r_sh_base_lo};
         3'd2:    w_rdata = {1'b0, r_sh_prg};
         3'd3:    w_rdata = {3'b000, r_sh_chr};
         3'd4:    w_rdata = 8'(r_sh_map);
         3'd5:    w_rdata = {1'b0, r_sh_flags};
         default: w_rdata = '0;
      endcase
   end

   // Shadow register writes, blocked while locked.
   always_ff @(posedge m2) begin
      if (reset) begin
         r_sh_base_hi <= '0;
         r_sh_base_lo <= '0;
         r_sh_prg     <= PRG_RST;
         r_sh_chr     <= '0;
         r_sh_map     <= '0;
         r_sh_flags   <= FLAGS_RST;
      end else if (w_wr_ok) begin
         case (bus.cfg_addr)
            3'd0:    r_sh_base_hi <= bus.cfg_data;
            3'd1:    r_sh_base_lo <= bus.cfg_data[4:0];
            3'd2:    r_sh_prg     <= bus.cfg_data[6:0];
            3'd3:    r_sh_chr     <= bus.cfg_data[4:0];
            3'd4:    r_sh_map     <= MAPPER_BITS'(bus.cfg_data);
            3'd5:    r_sh_flags   <= bus.cfg_data[6:0];
            default: ;
         endcase
      end
   end

   // Atomic commit of all shadow values to the active set, with optional lockout.
   always_ff @(posedge m2) begin
      if (reset) begin
         r_act_base  <= '0;
         r_act_prg   <= PRG_RST;
         r_act_chr   <= '0;
         r_act_map   <= '0;
         r_act_flags <= FLAGS_RST;
         r_locked    <= 1'b0;
      end else if (w_commit) begin
         r_act_base  <= {r_sh_base_hi, r_sh_base_lo};
         r_act_prg   <= r_sh_prg;
         r_act_chr   <= r_sh_chr;
         r_act_map   <= r_sh_map;
         r_act_flags <= r_sh_flags;
         r_locked    <= bus.cfg_data[7];
      end
   end

   // Mapper reset counter: reloads on reset or commit, counts down to 0 and holds.
   always_ff @(posedge m2) begin
      if (reset || w_commit) begin
         r_cnt <= CNT_W'(RESET_CYCLES);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // One-cycle-latency readback; a same-cycle write shows up a cycle later.
   always_ff @(posedge m2) begin
      if (reset) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= w_rdata;
      end
   end

   assign bus.cfg_rdata     = r_rdata;
   assign cpu_base          = r_act_base;
   assign prg_mask          = r_act_prg;
   assign chr_mask          = r_act_chr;
   assign mapper            = r_act_map;
   assign sram_enabled      = r_act_flags[0];
   assign sram_page         = r_act_flags[2:1];
   assign map_rom_on_6000   = r_act_flags[3];
   assign prg_write_enabled = r_act_flags[4];
   assign chr_write_enabled = r_act_flags[5];
   assign four_screen       = r_act_flags[6];
   assign locked            = r_locked;
   assign busy              = (r_cnt != '0);
   assign mapper_reset      = busy | reset;
endmodule

// File: tb/tb_cfg_register_loader.sv
// Scoreboard bench for cfg_register_loader: a register-array reference model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_cfg_register_loader;
   localparam int unsigned PULSE = 4;

   typedef struct packed {
      logic [7:0]  rdata;
      logic [12:0] cpu_base;
      logic [6:0]  prg_mask;
      logic [4:0]  chr_mask;
      logic [4:0]  mapper;
      logic [6:0]  flags;
      logic        locked;
      logic        mreset;
      logic        busy;
   } exp_t;

   logic        m2;
   logic        reset;
   logic [12:0] cpu_base;
   logic [6:0]  prg_mask;
   logic [4:0]  chr_mask;
   logic [4:0]  mapper;
   logic        sram_enabled, map_rom_on_6000, prg_write_enabled;
   logic        chr_write_enabled, four_screen;
   logic [1:0]  sram_page;
   logic        locked, mapper_reset, busy;

   cfg_register_loader_if bus ();

   cfg_register_loader #(.RESET_CYCLES(PULSE), .MAPPER_BITS(5)) dut (
      .m2                (m2),
      .reset             (reset),
      .bus               (bus),
      .cpu_base          (cpu_base),
      .prg_mask          (prg_mask),
      .chr_mask          (chr_mask),
      .mapper            (mapper),
      .sram_enabled      (sram_enabled),
      .map_rom_on_6000   (map_rom_on_6000),
      .prg_write_enabled (prg_write_enabled),
      .chr_write_enabled (chr_write_enabled),
      .four_screen       (four_screen),
      .sram_page         (sram_page),
      .locked            (locked),
      .mapper_reset      (mapper_reset),
      .busy              (busy)
   );

   initial m2 = 1'b0;
   always #5 m2 = ~m2;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   // Reference model: shadow and active register images as byte arrays.
   logic [7:0] m_sh  [8];
   logic [7:0] m_act [8];
   logic       m_locked;
   int         m_pulse_left;
   logic [7:0] m_rdata;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] store_mask(input logic [2:0] a);
      case (a)
         3'd0:    return 8'hFF;
         3'd1:    return 8'h1F;
         3'd2:    return 8'h7F;
         3'd3:    return 8'h1F;
         3'd4:    return 8'h1F;
         3'd5:    return 8'h7F;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_defaults();
      for (int i = 0; i < 8; i++) m_sh[i] = 8'h00;
      m_sh[2] = 8'h78;
      m_sh[5] = 8'h20;
      for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
      m_locked     = 1'b0;
      m_pulse_left = PULSE;
      m_rdata      = 8'h00;
   endtask

   // Drive one cycle of inputs, advance the model across the coming edge, queue the prediction.
   task automatic step(input logic rst, input logic wr, input logic [2:0] addr, input logic [7:0] data);
      exp_t e;
      logic commit;
      @(negedge m2);
      reset        = rst;
      bus.cfg_wr   = wr;
      bus.cfg_addr = addr;
      bus.cfg_data = data;
      if (rst) begin
         model_defaults();
      end else begin
         m_rdata = m_sh[addr];
         commit  = wr && !m_locked && addr == 3'd7 && data[0];
         if (wr && !m_locked) m_sh[addr] = data & store_mask(addr);
         if (commit) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            m_locked     = data[7];
            m_pulse_left = PULSE;
         end else if (m_pulse_left > 0) begin
            m_pulse_left--;
         end
      end
      e.rdata    = m_rdata;
      e.cpu_base = {m_act[0], m_act[1][4:0]};
      e.prg_mask = m_act[2][6:0];
      e.chr_mask = m_act[3][4:0];
      e.mapper   = m_act[4][4:0];
      e.flags    = m_act[5][6:0];
      e.locked   = m_locked;
      e.busy     = (m_pulse_left > 0);
      e.mreset   = rst || (m_pulse_left > 0);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [2:0] addr);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, addr, 8'($urandom));
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare it with the oldest prediction.
   initial begin
      exp_t e;
      logic [6:0] flags;
      forever begin
         @(posedge m2);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            flags = {four_screen, chr_write_enabled, prg_write_enabled,
                     map_rom_on_6000, sram_page, sram_enabled};
            chk("cfg_rdata",    16'(bus.cfg_rdata),  16'(e.rdata));
            chk("cpu_base",     16'(cpu_base),       16'(e.cpu_base));
            chk("prg_mask",     16'(prg_mask),       16'(e.prg_mask));
            chk("chr_mask",     16'(chr_mask),       16'(e.chr_mask));
            chk("mapper",       16'(mapper),         16'(e.mapper));
            chk("flags",        16'(flags),          16'(e.flags));
            chk("locked",       16'(locked),         16'(e.locked));
            chk("mapper_reset", 16'(mapper_reset),   16'(e.mreset));
            chk("busy",         16'(busy),           16'(e.busy));
         end
      end
   end

   // Stimulus: directed test-plan sequences followed by randomized traffic.
   initial begin
      logic [2:0] a;
      logic [7:0] d;
      reset        = 1'b1;
      bus.cfg_wr   = 1'b0;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = 8'h00;

      repeat (3) step(1'b1, 1'b0, 3'd0, 8'h00);
      idle(6, 3'd2);

      step(1'b0, 1'b1, 3'd0, 8'hA5);
      step(1'b0, 1'b1, 3'd1, 8'h13);
      step(1'b0, 1'b1, 3'd4, 8'h07);
      idle(1, 3'd0);
      idle(1, 3'd1);
      idle(1, 3'd4);
      step(1'b0, 1'b1, 3'd7, 8'h01);
      idle(1, 3'd0);
      step(1'b0, 1'b1, 3'd3, 8'h1B);
      step(1'b0, 1'b1, 3'd7, 8'h01);
      idle(8, 3'd3);

      step(1'b0, 1'b1, 3'd7, 8'h81);
      step(1'b0, 1'b1, 3'd2, 8'h00);
      step(1'b0, 1'b1, 3'd7, 8'h01);
      idle(6, 3'd2);
      repeat (2) step(1'b1, 1'b0, 3'd0, 8'h00);
      idle(6, 3'd2);

      step(1'b0, 1'b1, 3'd7, 8'h80);
      idle(2, 3'd0);
      step(1'b0, 1'b1, 3'd6, 8'hFF);
      idle(2, 3'd6);

      for (int i = 0; i < 1500; i++) begin
         a = 3'($urandom_range(0, 7));
         d = 8'($urandom);
         if (a == 3'd7 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
         if ($urandom_range(0, 79) == 0)
            step(1'b1, 1'b0, a, d);
         else
            step(1'b0, 1'($urandom_range(0, 1)), a, d);
      end

      repeat (3) @(negedge m2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
